// File: rtl/conv_stream_layer_pkg.sv
// Shared types and arithmetic helpers for the streaming convolution layer.
package conv_pkg;

  typedef enum logic {ACT_NONE, ACT_RELU} act_e;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} conv_state_e;

  // Width of the post-processing datapath; accumulators are sign-extended into it.
  localparam int unsigned SAT_W = 64;

  // Exact accumulator width for a KxK dot product of unsigned pixels and signed coefficients.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned kw,
                                            input int unsigned k);
    return dw + kw + 1 + $clog2(k * k);
  endfunction

  // Requantising shift, activation and saturation to a dw-bit channel value.
  function automatic logic [SAT_W-1:0] sat_act(input logic signed [SAT_W-1:0] acc,
                                               input int unsigned shift, input act_e act,
                                               input int unsigned dw);
    logic signed [SAT_W-1:0] v;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] one;
    one = SAT_W'(1);
    v   = acc >>> shift;
    if (act == ACT_RELU) begin
      hi = (one <<< dw) - one;
      lo = '0;
    end else begin
      hi = (one <<< (dw - 1)) - one;
      lo = -hi - one;
    end
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv_stream_layer_if.sv
// Pixel-in / multi-channel-out valid-ready stream bundle.
interface conv_stream_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_FILTERS = 4
);
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_FILTERS*DATA_WIDTH-1:0] out_data;
  logic                              out_last;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_last);

  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/conv_stream_layer_line_buffer.sv
// K-1 image rows plus a KxK window, kept as one pixel shift chain (newest pixel at index 0).
module conv_line_buffer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned IMGCOL      = 28
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       shift_en,
  input  logic [DATA_WIDTH-1:0]                      din,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win
);
  localparam int unsigned K      = KERNEL_SIZE;
  localparam int unsigned LB_LEN = (K - 1) * IMGCOL + K;

  logic [DATA_WIDTH-1:0] sr_q [LB_LEN];

  // Shift one pixel in per accepted input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LB_LEN; i++) sr_q[i] <= '0;
    end else if (shift_en) begin
      sr_q[0] <= din;
      for (int i = 1; i < LB_LEN; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  // Window tap (i,j) sits (K-1-i) rows and (K-1-j) columns behind the newest pixel.
  always_comb begin
    win = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win[(i*K+j)*DATA_WIDTH +: DATA_WIDTH] = sr_q[(K-1-i)*IMGCOL + (K-1-j)];
      end
    end
  end
endmodule

// File: rtl/conv_stream_layer.sv
// Streaming KxK convolution with NUM_FILTERS channels, stride, requantisation and activation.
module conv_stream_layer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KDATA_WIDTH = 8,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned IMGROW      = 28,
  parameter int unsigned IMGCOL      = 28,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned STRIDE      = 1,
  parameter int unsigned OUT_SHIFT   = 0,
  parameter string       ACTIVATION  = "RELU"
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic                                           k_wr_en,
  input  logic [$clog2(NUM_FILTERS)-1:0]                 k_wr_ch,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]     k_wr_idx,
  input  logic signed [KDATA_WIDTH-1:0]                  k_wr_data,
  conv_stream_if.slave                                   s_if,
  output logic                                           layer_done_out,
  output logic                                           busy
);
  localparam int unsigned K     = KERNEL_SIZE;
  localparam int unsigned KK    = K * K;
  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, KDATA_WIDTH, K);
  localparam int unsigned ROW_W = $clog2(IMGROW);
  localparam int unsigned COL_W = $clog2(IMGCOL);
  localparam act_e        ACT   = (ACTIVATION == "RELU") ? ACT_RELU : ACT_NONE;
  localparam logic        KPAR  = 1'((K - 1) % 2);

  if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
    $error("conv_stream_layer: STRIDE must be 1 or 2");
  end
  if (((IMGROW - K) % STRIDE) != 0 || ((IMGCOL - K) % STRIDE) != 0) begin : g_bad_geom
    $error("conv_stream_layer: frame size not reachable with this STRIDE");
  end
  if (ACTIVATION != "RELU" && ACTIVATION != "NONE") begin : g_bad_act
    $error("conv_stream_layer: ACTIVATION must be RELU or NONE");
  end
  if (ACC_W > SAT_W) begin : g_bad_acc
    $error("conv_stream_layer: accumulator too wide");
  end

  conv_state_e state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic done_q, busy_q;
  logic signed [KDATA_WIDTH-1:0] kern_q [NUM_FILTERS][KK];
  logic [KK*DATA_WIDTH-1:0] win_c;
  logic [NUM_FILTERS*ACC_W-1:0] acc_flat_c, s1_acc_q;
  logic [NUM_FILTERS*DATA_WIDTH-1:0] res_c, out_data_q;
  logic win_vld_q, win_last_q, s1_vld_q, s1_last_q, out_valid_q, out_last_q;
  logic advance_c, in_ready_c, accept_c, emit_c, last_pix_c, out_fire_c;

  assign advance_c  = !out_valid_q || s_if.out_ready;
  assign in_ready_c = (state_q == STREAM) && advance_c;
  assign accept_c   = s_if.in_valid && in_ready_c;
  assign out_fire_c = out_valid_q && s_if.out_ready;
  assign last_pix_c = (row_q == ROW_W'(IMGROW - 1)) && (col_q == COL_W'(IMGCOL - 1));
  assign emit_c     = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1)) &&
                      ((STRIDE == 1) || ((row_q[0] == KPAR) && (col_q[0] == KPAR)));

  assign s_if.in_ready  = in_ready_c;
  assign s_if.out_valid = out_valid_q;
  assign s_if.out_data  = out_data_q;
  assign s_if.out_last  = out_last_q;
  assign layer_done_out = done_q;
  assign busy           = busy_q;

  conv_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .KERNEL_SIZE(K),
    .IMGCOL     (IMGCOL)
  ) u_line_buffer (
    .clk     (clk),
    .rst     (rst),
    .shift_en(accept_c),
    .din     (s_if.in_data),
    .win     (win_c)
  );

  // Frame control: state, raster counters, done pulse and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= STREAM;
          row_q   <= '0;
          col_q   <= '0;
          busy_q  <= 1'b1;
        end
        STREAM: if (accept_c) begin
          if (col_q == COL_W'(IMGCOL - 1)) begin
            col_q <= '0;
            row_q <= row_q + ROW_W'(1);
          end else begin
            col_q <= col_q + COL_W'(1);
          end
          if (last_pix_c) state_q <= DRAIN;
        end
        DRAIN: if (out_fire_c && out_last_q) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Kernel coefficient store, writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < NUM_FILTERS; f++)
        for (int t = 0; t < KK; t++) kern_q[f][t] <= '0;
    end else if (state_q == IDLE && k_wr_en &&
                 32'(k_wr_ch) < NUM_FILTERS && 32'(k_wr_idx) < KK) begin
      kern_q[k_wr_ch][k_wr_idx] <= k_wr_data;
    end
  end

  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_mac
    logic signed [ACC_W-1:0] acc_c;
    // Exact signed dot product of the current window with filter f.
    always_comb begin
      acc_c = '0;
      for (int t = 0; t < KK; t++) begin
        acc_c = acc_c + ACC_W'($signed({1'b0, win_c[t*DATA_WIDTH +: DATA_WIDTH]})) *
                        ACC_W'(kern_q[f][t]);
      end
    end
    assign acc_flat_c[f*ACC_W +: ACC_W] = acc_c;
  end

  // Requantise, activate and saturate every channel from the S1 sums.
  always_comb begin
    res_c = '0;
    for (int f = 0; f < NUM_FILTERS; f++) begin
      res_c[f*DATA_WIDTH +: DATA_WIDTH] =
        DATA_WIDTH'(sat_act(SAT_W'($signed(s1_acc_q[f*ACC_W +: ACC_W])), OUT_SHIFT, ACT,
                            DATA_WIDTH));
    end
  end

  // Window-valid, S1 and S2 stages; all hold together while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_vld_q   <= 1'b0;
      win_last_q  <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_acc_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (advance_c) begin
      win_vld_q   <= accept_c && emit_c;
      win_last_q  <= accept_c && last_pix_c;
      s1_vld_q    <= win_vld_q;
      s1_last_q   <= win_vld_q && win_last_q;
      if (win_vld_q) s1_acc_q <= acc_flat_c;
      out_valid_q <= s1_vld_q;
      out_last_q  <= s1_vld_q && s1_last_q;
      if (s1_vld_q) out_data_q <= res_c;
    end
  end
endmodule

// File: doc/conv_stream_layer.md
# conv_stream_layer

Streaming, parametrised successor to `conv_layer`: a valid-ready pixel-stream 2D convolution with NUM_FILTERS output channels, configurable stride, requantising right-shift, selectable activation and saturation. It replaces whole-frame array ports with line buffers, so it sits between an image source (DMA or previous layer) and a pooling or next conv stage in the CNN pipeline. Per-filter kernels are loaded through a write port while idle. A one-cycle `layer_done_out` marks the end of the frame.

## Interface
- DATA_WIDTH, 8: pixel width; unsigned on input, output width per channel.
- KDATA_WIDTH, 8: kernel coefficient width, signed two's complement.
- KERNEL_SIZE, 5: K, with K≥2.
- IMGROW, 28 / IMGCOL, 28: input frame dimensions.
- NUM_FILTERS, 4: number of output channels.
- STRIDE, 1: 1 or 2. (IMGROW-K)%STRIDE and (IMGCOL-K)%STRIDE must both be 0, else `$error` at elaboration.
- OUT_SHIFT, 0: arithmetic right shift applied before activation.
- ACTIVATION, "RELU": "RELU" or "NONE".

Ports. Reset is asynchronous and active-high.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; starts a frame from IDLE.
- k_wr_en  in  1  kernel write strobe.
- k_wr_ch  in  $clog2(NUM_FILTERS)  filter index.
- k_wr_idx  in  $clog2(K*K)  coefficient index, row-major (row*K+col).
- k_wr_data  in  KDATA_WIDTH  coefficient.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  DATA_WIDTH  pixel, raster order.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  NUM_FILTERS*DATA_WIDTH  channel f at bits [f*DATA_WIDTH +: DATA_WIDTH].
- out_last  out  1  qualifies the final output pixel.
- layer_done_out  out  1  one-cycle frame-complete pulse.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: kernel writes accepted, `in_ready`=0. `start` moves to STREAM and clears the row, col and output counters.
  - STREAM: accepts pixels. The handshake accepting pixel IMGROW*IMGCOL-1 moves to DRAIN.
  - DRAIN: `in_ready`=0. Waits until both pipeline stages are empty and the `out_last` beat has completed.
  - DONE: `layer_done_out`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. `k_wr_en` outside IDLE is ignored and the kernel is unchanged.
- Line buffer: holds K-1 rows of IMGCOL pixels plus a KxK window. The window shifts on every accepted pixel, using counters row/col.
- Output condition: an output is produced for an accepted pixel when row≥K-1, col≥K-1, (row-K+1)%STRIDE==0 and (col-K+1)%STRIDE==0.
- Output count: ((IMGROW-K)/STRIDE+1)*((IMGCOL-K)/STRIDE+1), in raster order.
- Arithmetic: ACC_W = DATA_WIDTH+KDATA_WIDTH+1+$clog2(K*K). acc = Σ zero-extended pixel × signed coefficient. The sum is exact, with no intermediate overflow.
- Post-processing: v = acc >>> OUT_SHIFT.
  - RELU: v<0 gives 0. Otherwise the result is saturated to 2^DATA_WIDTH-1 (unsigned result).
  - NONE: saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] (signed result).
- `out_last` is set only on the final output beat of the frame.

## Timing
- Pipeline: S1 registers the per-filter MAC sums; S2 registers the shifted, activated and saturated result into `out_data`.
- Latency: an accepted pixel that completes a window appears on `out_valid` 2 cycles after the accepting edge, with no stall.
- advance = !out_valid || out_ready. Both stages move only on advance.
- in_ready = (state==STREAM) && advance. With `out_ready` held at 1, throughput is 1 pixel/cycle.
- While `out_valid`=1 and `out_ready`=0:
  - `out_data` and `out_last` stay stable.
  - The S1 contents are held.
  - No pixel is accepted or lost.
- DONE is entered the cycle after the `out_last` handshake.
- Reset values, all outputs: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `layer_done_out`=0, `busy`=0.
- Reset clears all internal state: state=IDLE, counters, line buffer valids, kernel registers=0.
- Reset mid-frame: outputs drop immediately (asynchronously). The partial frame is discarded, and the kernel must be reloaded.

## Structure
- Shared package `conv_pkg`:
  - `act_e` (ACT_NONE, ACT_RELU).
  - `conv_state_e` (IDLE, STREAM, DRAIN, DONE).
  - `acc_width()` function.
  - `sat_act()` function: shift, activation and saturation.
- Sub-module `conv_line_buffer`: K-1 row FIFOs plus the KxK window, with shift enable. It is instantiated once and shared by all filters.
- The MAC array is generated per filter in the top level.

## Test plan
Base configuration: 6x6 frame, K=3, NUM_FILTERS=2, STRIDE=1, OUT_SHIFT=0, RELU, unless a line says otherwise.
- Kernel-load check: filter0 all 0x01, filter1 all 0xFF, all pixels 1 → 16 beats with ch0=9, ch1=0. `out_last` on beat 16. `layer_done_out` pulses one cycle after that beat.
- Saturation: pixels 255, kernel all 0x7F → RELU gives 255. With ACTIVATION="NONE" → 127; with filter all 0x80 → -128 (0x80).
- Latency and shift: ramp image p=r*6+c, centre coefficient 1, all others 0, OUT_SHIFT=1 → out[r][c]=((r+1)*6+c+1)>>1, e.g. out[0][0]=3. First `out_valid` 2 cycles after pixel (2,2) is accepted.
- Backpressure: `out_ready`=0 for 5 cycles mid-frame → `in_ready`=0 and `out_data` stable throughout. The output sequence is identical to the unstalled run.
- Stride: STRIDE=2, 7x7 frame, ramp image, centre-1 kernel → 9 outputs taken at positions 1,3,5, i.e. out[0][0]=8, out[2][2]=40.
- Reset and ignored writes: assert `rst` after 20 pixels → all outputs 0 at once. Reload kernel, `start`, run a full frame → correct outputs. A `k_wr_en` issued during STREAM does not change any result.
